// File: rtl/instruction_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into 32-bit words
// and drives the instruction RAM write port while holding the CPU in reset.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00000000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        InReady,
  output logic        MemWrite,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      r_state;
  logic [15:0] r_n;
  logic [15:0] r_idx;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic        r_in_ready;
  logic        r_mem_write;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic [15:0] w_idx_next;
  logic [15:0] w_n_full;
  logic        w_in_range;

  assign w_accept   = InValid && r_in_ready;
  assign w_idx_next = r_idx + 16'd1;
  assign w_n_full   = {r_n[15:8], InData};
  // Words past the RAM capacity are still consumed, just never written.
  assign w_in_range = ({1'b0, r_idx} < DEPTH_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_HDR_HI;
      r_n         <= 16'd0;
      r_idx       <= 16'd0;
      r_byte_cnt  <= 2'd0;
      r_shift     <= 24'd0;
      r_in_ready  <= 1'b1;
      r_mem_write <= 1'b0;
      r_waddr     <= BASE_ADDR;
      r_wdata     <= 32'd0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        S_HDR_HI: begin
          if (w_accept) begin
            r_n[15:8] <= InData;
            r_state   <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (w_accept) begin
            r_n[7:0] <= InData;
            r_error  <= ({1'b0, w_n_full} > DEPTH_W);
            if (w_n_full == 16'd0) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state     <= S_WRITE;
              r_in_ready  <= 1'b0;
              r_mem_write <= w_in_range;
              r_wdata     <= {r_shift, InData};
              r_waddr     <= BASE_ADDR + {14'd0, r_idx, 2'b00};
            end else begin
              r_shift <= {r_shift[15:0], InData};
            end
          end
        end
        S_WRITE: begin
          r_idx <= w_idx_next;
          if (w_idx_next == r_n) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state    <= S_DATA;
            r_in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (Start) begin
            r_state    <= S_HDR_HI;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_idx      <= 16'd0;
            r_n        <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_error    <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_HDR_HI;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign InReady      = r_in_ready;
  assign MemWrite     = r_mem_write;
  assign WriteAddress = r_waddr;
  assign WriteData    = r_wdata;
  assign CpuHold      = r_cpu_hold;
  assign Done         = r_done;
  assign Error        = r_error;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time loader that writes a program image into the pipeline's instruction memory. It accepts a big-endian byte stream over a valid/ready handshake and assembles 32-bit words. Each word is written to a word-indexed instruction RAM whose write port mirrors the fetch-side read port (Address[11:2] indexing). The processor is held in reset until the image is complete.

## Interface
- BASE_ADDR, 32'h00000000, byte address of word 0 of the image
- DEPTH, 1024, instruction RAM capacity in words (power of two, ≤ 1024)
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- Start  input  1  re-arm pulse; honoured only in DONE
- InValid  input  1  InData holds a valid byte
- InData  input  8  stream byte
- InReady  output  1  loader accepts InData this cycle
- MemWrite  output  1  one-cycle write strobe to instruction RAM
- WriteAddress  output  32  byte address of the word being written (bits [1:0] = 0)
- WriteData  output  32  assembled instruction word
- CpuHold  output  1  holds the processor in reset while loading
- Done  output  1  image fully received
- Error  output  1  sticky: header word count exceeded DEPTH

## Operation
- Stream format: 2-byte word count N (MSB first), then N words of 4 bytes each, MSB first (first byte → WriteData[31:24]).
- States:
  - HDR_HI: capture N[15:8] → HDR_LO.
  - HDR_LO: capture N[7:0]; if N==0 → DONE, else → DATA. Error is set here if N > DEPTH.
  - DATA: shift bytes in using a 2-bit byte counter; on the 4th accepted byte → WRITE.
  - WRITE: MemWrite=1 for exactly one cycle if idx < DEPTH (suppressed otherwise). Then idx++; if idx+1 == N → DONE, else → DATA with the byte counter at 0.
  - DONE: Done=1, CpuHold=0; Start=1 → HDR_HI, clearing idx, N, the byte counter and Error.
- A byte is accepted only when InValid && InReady. InReady=1 in HDR_HI, HDR_LO and DATA; 0 in WRITE and DONE.
- WriteAddress = BASE_ADDR + (idx << 2); idx is a 16-bit word index.
- Overflow: words with idx ≥ DEPTH are still consumed from the stream, but no MemWrite is issued. Done is still reached after N words.
- Start outside DONE is ignored.
- No partial words are written. A stream that stalls mid-word leaves the loader waiting indefinitely.

## Timing
- Reset (asynchronous, reset=0), all immediate:
  - state=HDR_HI
  - InReady=1
  - MemWrite=0
  - WriteAddress=BASE_ADDR
  - WriteData=0
  - CpuHold=1
  - Done=0
  - Error=0
  - idx, N and byte counter = 0
- Reset mid-word or mid-image discards all progress; RAM contents already written are not touched.
- Latency: the 4th byte is accepted at edge k; MemWrite, WriteAddress and WriteData are valid during cycle k+1 (registered outputs).
- Peak throughput: 4 bytes per 5 cycles (one WRITE bubble per word).
- Done and CpuHold change in the cycle after the final WRITE cycle, or after the HDR_LO accept when N==0.
- WriteData and WriteAddress hold their last values outside WRITE. MemWrite is never high for 2 consecutive cycles.
- InValid gaps of any length between bytes are tolerated. Bytes presented while InReady=0 are not consumed and must be held by the source.

## Test plan
- Basic load: release reset, stream 00 02 20 10 00 00 20 02 00 14 with InValid held high → MemWrite pulses at WriteAddress 0x0 (data 0x20100000) and 0x4 (data 0x20020014); Done=1 and CpuHold=0 one cycle after the 2nd write.
- Empty image: stream 00 00 → no MemWrite; Done=1 the cycle after the 2nd byte is accepted; InReady=0 thereafter.
- Backpressure/gaps: N=1, word 0x8c110000 with random InValid gaps of 0–5 cycles → exactly one MemWrite, data 0x8c110000; InReady=0 during the WRITE cycle; no byte lost or duplicated.
- Overflow: DEPTH=4, N=5, words 1..5 → writes at 0x0–0xC only; the 5th word is consumed with no MemWrite; Error=1 and Done=1.
- Reset mid-word: after header 00 01 and 2 data bytes, pulse reset low → all outputs at reset values; a fresh stream 00 01 AA BB CC DD writes 0xAABBCCDD at 0x0.
- Re-arm: after Done, pulse Start → Done=0, CpuHold=1, Error cleared; a second image of N=1 writes at BASE_ADDR; Start asserted mid-load has no effect.
